// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyph codes (bits 6:0 = g..a)
// used by both the display encoder and the frame reader, plus the decode result type.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [3:0] nibble;
    logic       blank;
    logic       err;
  } seg7_dec_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern decoder: active-low code to hex nibble,
// blank flag, decimal-point flag and an error flag for unknown patterns.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [7:0] code,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       dp,
  output logic       err
);

  seg7_dec_t dec;

  // Map segment bits to a glyph; anything unrecognised flags an error with nibble 0.
  always_comb begin
    dec = '0;
    case (code[6:0])
      SEG_0:     dec.nibble = 4'h0;
      SEG_1:     dec.nibble = 4'h1;
      SEG_2:     dec.nibble = 4'h2;
      SEG_3:     dec.nibble = 4'h3;
      SEG_4:     dec.nibble = 4'h4;
      SEG_5:     dec.nibble = 4'h5;
      SEG_6:     dec.nibble = 4'h6;
      SEG_7:     dec.nibble = 4'h7;
      SEG_8:     dec.nibble = 4'h8;
      SEG_9:     dec.nibble = 4'h9;
      SEG_A:     dec.nibble = 4'hA;
      SEG_B:     dec.nibble = 4'hB;
      SEG_C:     dec.nibble = 4'hC;
      SEG_D:     dec.nibble = 4'hD;
      SEG_E:     dec.nibble = 4'hE;
      SEG_F:     dec.nibble = 4'hF;
      SEG_BLANK: dec.blank  = 1'b1;
      default:   dec.err    = 1'b1;
    endcase
  end

  assign nibble = dec.nibble;
  assign blank  = dec.blank;
  assign err    = dec.err;
  // DP is active-low and independent of the segment decode.
  assign dp     = ~code[7];

endmodule

// File: rtl/seg7_frame_reader.sv
// Seven-segment frame reader: accepts one digit pattern per transfer in scan
// order (HEX7 down to HEX0), decodes it into a shadow frame and presents each
// completed frame on a valid/ready handshake.
module seg7_frame_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter bit CHECK_ORDER = 1'b1
) (
  input  logic                    CLOCK_50,
  input  logic                    RST,
  input  logic                    seg_valid,
  output logic                    seg_ready,
  input  logic [2:0]              seg_sel,
  input  logic [7:0]              seg_code,
  output logic                    frm_valid,
  input  logic                    frm_ready,
  output logic [4*NUM_DIGITS-1:0] frm_value,
  output logic [NUM_DIGITS-1:0]   frm_blank,
  output logic [NUM_DIGITS-1:0]   frm_dp,
  output logic [NUM_DIGITS-1:0]   frm_err,
  output logic                    seq_err
);

  // COLLECT gathers digits; LOAD copies the shadow frame out; HOLD waits for frm_ready.
  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  localparam logic [2:0] IDX_TOP = 3'(NUM_DIGITS - 1);

  logic [1:0] state;
  logic [2:0] idx;

  logic [3:0] dec_nibble;
  logic       dec_blank;
  logic       dec_dp;
  logic       dec_err;

  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_err;

  logic       xfer;
  logic       in_order;
  logic       restart;
  logic       take;
  logic [2:0] slot;

  seg7_decode u_decode (
    .code   (seg_code),
    .nibble (dec_nibble),
    .blank  (dec_blank),
    .dp     (dec_dp),
    .err    (dec_err)
  );

  assign xfer     = seg_valid && seg_ready;
  // With order checking off the index is ignored and arrival order decides the slot.
  assign in_order = !CHECK_ORDER || (seg_sel == idx);
  // An out-of-order HEX7 is not thrown away: it starts the next frame at once.
  assign restart  = !in_order && (seg_sel == IDX_TOP);
  assign take     = xfer && (in_order || restart);
  assign slot     = in_order ? idx : IDX_TOP;

  // Control: scan index, frame state, ready/valid handshakes and sequence-error pulse.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state     <= ST_COLLECT;
      idx       <= IDX_TOP;
      seg_ready <= 1'b1;
      frm_valid <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      seq_err <= 1'b0;
      case (state)
        ST_COLLECT: begin
          if (xfer) begin
            if (!in_order) begin
              seq_err <= 1'b1;
              idx     <= restart ? IDX_TOP - 3'd1 : IDX_TOP;
            end else if (idx == 3'd0) begin
              state     <= ST_LOAD;
              seg_ready <= 1'b0;
            end else begin
              idx <= idx - 3'd1;
            end
          end
        end
        ST_LOAD: begin
          state     <= ST_HOLD;
          frm_valid <= 1'b1;
        end
        ST_HOLD: begin
          if (frm_ready) begin
            state     <= ST_COLLECT;
            frm_valid <= 1'b0;
            seg_ready <= 1'b1;
            idx       <= IDX_TOP;
          end
        end
        default: begin
          state     <= ST_COLLECT;
          frm_valid <= 1'b0;
          seg_ready <= 1'b1;
          idx       <= IDX_TOP;
        end
      endcase
    end
  end

  // Data: fill the shadow slot for each accepted digit, copy the frame out in LOAD.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      sh_value  <= '0;
      sh_blank  <= '0;
      sh_dp     <= '0;
      sh_err    <= '0;
      frm_value <= '0;
      frm_blank <= '0;
      frm_dp    <= '0;
      frm_err   <= '0;
    end else begin
      if (take) begin
        sh_value[{slot, 2'b00} +: 4] <= dec_nibble;
        sh_blank[slot]               <= dec_blank;
        sh_dp[slot]                  <= dec_dp;
        sh_err[slot]                 <= dec_err;
      end
      if (state == ST_LOAD) begin
        frm_value <= sh_value;
        frm_blank <= sh_blank;
        frm_dp    <= sh_dp;
        frm_err   <= sh_err;
      end
    end
  end

endmodule

// File: tb/tb_seg7_frame_reader.sv
// Bench for seg7_frame_reader: glyph table, directed multi-cycle sequences and
// randomized traffic compared every cycle against a transaction-level model.
module tb_seg7_frame_reader;

  logic        CLOCK_50 = 1'b0;
  logic        RST;
  logic        seg_valid;
  logic        seg_ready;
  logic [2:0]  seg_sel;
  logic [7:0]  seg_code;
  logic        frm_valid;
  logic        frm_ready;
  logic [31:0] frm_value;
  logic [7:0]  frm_blank;
  logic [7:0]  frm_dp;
  logic [7:0]  frm_err;
  logic        seq_err;

  seg7_frame_reader #(.NUM_DIGITS(8), .CHECK_ORDER(1'b1)) dut (
    .CLOCK_50  (CLOCK_50),
    .RST       (RST),
    .seg_valid (seg_valid),
    .seg_ready (seg_ready),
    .seg_sel   (seg_sel),
    .seg_code  (seg_code),
    .frm_valid (frm_valid),
    .frm_ready (frm_ready),
    .frm_value (frm_value),
    .frm_blank (frm_blank),
    .frm_dp    (frm_dp),
    .frm_err   (frm_err),
    .seq_err   (seq_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int nvec = 0;
  int nfail = 0;

  // Glyph codes for 0..F, index = hex value.
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: frame-in-progress, next expected index, pending/shown frame.
  int          exp_idx;
  int          phase;      // 0 collecting, 1 frame completed (output next edge), 2 frame shown
  logic        exp_seq;
  logic [31:0] s_val, e_val;
  logic [7:0]  s_blk, s_dp, s_err, e_blk, e_dp, e_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic ref_decode(input logic [7:0] c, output logic [3:0] n,
                            output logic b, output logic d, output logic e);
    n = 4'h0; b = 1'b0; e = 1'b1; d = ~c[7];
    if (c[6:0] == 7'h7F) begin
      b = 1'b1; e = 1'b0;
    end else begin
      for (int k = 0; k < 16; k++)
        if (glyph[k] == c[6:0]) begin
          n = 4'(k); e = 1'b0;
        end
    end
  endtask

  task automatic model_reset();
    exp_idx = 7; phase = 0; exp_seq = 1'b0;
    s_val = '0; s_blk = '0; s_dp = '0; s_err = '0;
    e_val = '0; e_blk = '0; e_dp = '0; e_err = '0;
  endtask

  task automatic store(input int k, input logic [7:0] c);
    logic [3:0] n;
    logic b, d, e;
    ref_decode(c, n, b, d, e);
    s_val[4*k +: 4] = n;
    s_blk[k] = b; s_dp[k] = d; s_err[k] = e;
  endtask

  task automatic model_edge(input logic v, input logic [2:0] sel, input logic [7:0] c,
                            input logic rdy);
    exp_seq = 1'b0;
    case (phase)
      0: if (v) begin
        if (int'(sel) != exp_idx) begin
          exp_seq = 1'b1;
          if (sel == 3'd7) begin
            store(7, c); exp_idx = 6;
          end else begin
            exp_idx = 7;
          end
        end else begin
          store(exp_idx, c);
          if (exp_idx == 0) phase = 1;
          else exp_idx--;
        end
      end
      1: begin
        e_val = s_val; e_blk = s_blk; e_dp = s_dp; e_err = s_err;
        phase = 2;
      end
      default: if (rdy) begin
        phase = 0; exp_idx = 7;
      end
    endcase
  endtask

  task automatic check_all();
    chk("seg_ready", 32'(seg_ready), 32'(phase == 0));
    chk("frm_valid", 32'(frm_valid), 32'(phase == 2));
    chk("seq_err",   32'(seq_err),   32'(exp_seq));
    chk("frm_value", frm_value, e_val);
    chk("frm_blank", 32'(frm_blank), 32'(e_blk));
    chk("frm_dp",    32'(frm_dp),    32'(e_dp));
    chk("frm_err",   32'(frm_err),   32'(e_err));
  endtask

  // One clock: drive inputs, let the edge happen, update model, compare.
  task automatic cyc(input logic v, input logic [2:0] sel, input logic [7:0] c, input logic rdy);
    seg_valid = v; seg_sel = sel; seg_code = c; frm_ready = rdy;
    @(posedge CLOCK_50);
    model_edge(v, sel, c, rdy);
    #1;
    check_all();
  endtask

  task automatic send_frame(input logic [63:0] codes, input logic rdy);
    for (int k = 7; k >= 0; k--) cyc(1'b1, 3'(k), codes[8*k +: 8], rdy);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    model_reset();
    #2;
    check_all();
    @(posedge CLOCK_50);
    #1;
    check_all();
    RST = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [7:0] code;
    logic [3:0] nib;
    logic       blank;
    logic       dp;
    logic       err;
  } vec_t;

  vec_t tbl [22];

  initial begin
    logic [31:0] snap;
    logic [7:0]  rc;
    logic [2:0]  rs;
    logic        dpb;
    int          r;

    tbl[0]  = '{8'hC0, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{8'hF9, 4'h1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{8'hA4, 4'h2, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{8'hB0, 4'h3, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{8'h99, 4'h4, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{8'h92, 4'h5, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{8'h82, 4'h6, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{8'hF8, 4'h7, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{8'h80, 4'h8, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{8'h90, 4'h9, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{8'h88, 4'hA, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{8'h83, 4'hB, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{8'hC6, 4'hC, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{8'hA1, 4'hD, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{8'h86, 4'hE, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{8'h8E, 4'hF, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{8'h40, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{8'h00, 4'h8, 1'b0, 1'b1, 1'b0};
    tbl[18] = '{8'hFF, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{8'h7F, 4'h0, 1'b1, 1'b1, 1'b0};
    tbl[20] = '{8'hFE, 4'h0, 1'b0, 1'b0, 1'b1};
    tbl[21] = '{8'h55, 4'h0, 1'b0, 1'b1, 1'b1};

    seg_valid = 1'b0; seg_sel = 3'd0; seg_code = 8'hFF; frm_ready = 1'b0;
    do_reset();

    // Single frame: blanks then "12"; frm_valid one cycle after the HEX0 transfer.
    send_frame({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4}, 1'b1);
    chk("single_valid_early", 32'(frm_valid), 32'd0);
    cyc(1'b0, 3'd0, 8'hFF, 1'b1);
    chk("single_valid", 32'(frm_valid), 32'd1);
    chk("single_value", frm_value, 32'h0000_0012);
    chk("single_blank", 32'(frm_blank), 32'h0000_00FC);
    chk("single_dp",    32'(frm_dp),    32'd0);
    chk("single_err",   32'(frm_err),   32'd0);
    cyc(1'b0, 3'd0, 8'hFF, 1'b1);
    chk("single_release", 32'(seg_ready), 32'd1);

    // Glyph table: each code as HEX0 behind blank digits.
    for (int i = 0; i < 22; i++) begin
      send_frame({56'hFFFF_FFFF_FFFF_FF, tbl[i].code}, 1'b0);
      cyc(1'b0, 3'd0, 8'hFF, 1'b0);
      chk("tbl_nibble", 32'(frm_value[3:0]), 32'(tbl[i].nib));
      chk("tbl_blank",  32'(frm_blank[0]),   32'(tbl[i].blank));
      chk("tbl_dp",     32'(frm_dp[0]),      32'(tbl[i].dp));
      chk("tbl_err",    32'(frm_err[0]),     32'(tbl[i].err));
      cyc(1'b0, 3'd0, 8'hFF, 1'b1);
    end

    // Invalid pattern on HEX3 only.
    send_frame({8'hF8, 8'h82, 8'h92, 8'h99, 8'hFE, 8'hA4, 8'hF9, 8'hC0}, 1'b1);
    cyc(1'b0, 3'd0, 8'hFF, 1'b0);
    chk("inv_value", frm_value, 32'h7654_0210);
    chk("inv_err",   32'(frm_err), 32'h0000_0008);
    chk("inv_blank", 32'(frm_blank), 32'd0);
    cyc(1'b0, 3'd0, 8'hFF, 1'b1);

    // Order error: 7,6,4 then a clean frame.
    cyc(1'b1, 3'd7, 8'hC0, 1'b1);
    cyc(1'b1, 3'd6, 8'hC0, 1'b1);
    chk("ord_no_err", 32'(seq_err), 32'd0);
    cyc(1'b1, 3'd4, 8'hC0, 1'b1);
    chk("ord_seq_err", 32'(seq_err), 32'd1);
    send_frame({8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80}, 1'b1);
    cyc(1'b0, 3'd0, 8'hFF, 1'b1);
    chk("ord_value", frm_value, 32'hFEDC_BA98);
    cyc(1'b0, 3'd0, 8'hFF, 1'b1);

    // HEX7 arriving mid-frame restarts the frame with that digit.
    cyc(1'b1, 3'd7, 8'hC0, 1'b1);
    cyc(1'b1, 3'd6, 8'hC0, 1'b1);
    cyc(1'b1, 3'd5, 8'hC0, 1'b1);
    cyc(1'b1, 3'd7, 8'h79, 1'b1);
    chk("restart_seq_err", 32'(seq_err), 32'd1);
    for (int k = 6; k >= 0; k--) cyc(1'b1, 3'(k), 8'hA4, 1'b1);
    cyc(1'b0, 3'd0, 8'hFF, 1'b1);
    chk("restart_value", frm_value, 32'h1222_2222);
    cyc(1'b0, 3'd0, 8'hFF, 1'b1);

    // Back-pressure: frame held 20 cycles with seg_valid high.
    send_frame({8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80}, 1'b0);
    cyc(1'b1, 3'd7, 8'hC0, 1'b0);
    snap = frm_value;
    chk("bp_value", snap, 32'h1234_5678);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 3'd7, 8'hC0, 1'b0);
      chk("bp_ready_low", 32'(seg_ready), 32'd0);
      chk("bp_stable", frm_value, snap);
    end
    cyc(1'b1, 3'd7, 8'hC0, 1'b1);
    chk("bp_ready_back", 32'(seg_ready), 32'd1);
    send_frame({8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h79}, 1'b1);
    cyc(1'b0, 3'd0, 8'hFF, 1'b1);
    chk("bp_next_value", frm_value, 32'h0000_0001);
    cyc(1'b0, 3'd0, 8'hFF, 1'b1);

    // Reset mid-frame discards the partial frame.
    for (int k = 7; k >= 4; k--) cyc(1'b1, 3'(k), 8'h80, 1'b1);
    do_reset();
    chk("rst_value", frm_value, 32'd0);
    chk("rst_seq", 32'(seq_err), 32'd0);
    send_frame({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0, 8'hF9, 8'hA4, 8'hB0}, 1'b1);
    cyc(1'b0, 3'd0, 8'hFF, 1'b1);
    chk("rst_frame_value", frm_value, 32'h0000_0123);
    chk("rst_frame_blank", 32'(frm_blank), 32'h0000_00F0);
    cyc(1'b0, 3'd0, 8'hFF, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 9));
      dpb = 1'($urandom_range(0, 1));
      if (r < 7) rc = {dpb, glyph[$urandom_range(0, 15)]};
      else if (r == 7) rc = {dpb, 7'h7F};
      else rc = 8'($urandom);
      if ($urandom_range(0, 19) == 0) rs = 3'($urandom_range(0, 7));
      else rs = 3'(exp_idx);
      cyc(1'($urandom_range(0, 4) != 0), rs, rc, 1'($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/seg7_frame_reader.md
Name: seg7_frame_reader

Overview:
- Receive end of the board's 8-digit seven-segment display path.
- The display encoder sends one digit pattern per transfer. Transfers arrive in scan order, HEX7 first, down to HEX0.
- This block decodes each active-low pattern back to a hex nibble, a blank flag and a decimal-point flag, then assembles a full 8-digit frame.
- Each completed frame is presented on a valid/ready output handshake. Used for loopback self-check of display drivers and for capturing what the display shows.

Parameters:
- NUM_DIGITS, 8, digits per frame; the index width is fixed at 3 bits.
- CHECK_ORDER, 1, when 1 a digit index out of sequence aborts the frame; when 0 the index is ignored and digits are taken in arrival order.

Ports:
- CLOCK_50  in  1  system clock; all state on its rising edge.
- RST  in  1  asynchronous active-high reset.
- seg_valid  in  1  an input digit transfer is offered.
- seg_ready  out  1  block accepts a digit this cycle.
- seg_sel  in  3  digit index of the offered pattern, 7 = HEX7.
- seg_code  in  8  active-low pattern; bit7 = DP, bits6:0 = segments g..a.
- frm_valid  out  1  a completed frame is held on the frame outputs.
- frm_ready  in  1  downstream accepts the frame.
- frm_value  out  32  decoded nibbles; [31:28] = HEX7 … [3:0] = HEX0.
- frm_blank  out  8  bit i set: digit i was blank (bits6:0 = 7'h7F).
- frm_dp  out  8  bit i set: digit i had its DP lit (bit7 = 0).
- frm_err  out  8  bit i set: digit i pattern did not decode.
- seq_err  out  1  one-cycle pulse when a frame is aborted by an out-of-order index.

Behaviour:
- Reset, asynchronous and active-high:
  - state = COLLECT, expected index = 7.
  - seg_ready = 1, frm_valid = 0, seq_err = 0.
  - All frame outputs and shadow registers are cleared to 0.
- Decode on bits6:0 only:
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F.
  - 7F → blank, nibble 0.
  - Any other pattern → err bit set, nibble 0.
  - DP flag is the inverse of bit7 and is independent of decode.
- A digit transfer occurs when seg_valid && seg_ready.
- State COLLECT:
  - On each transfer, the decoded results are written into the shadow slot for the expected index, and the index decrements.
  - If CHECK_ORDER = 1 and seg_sel ≠ expected index:
    - The digit is discarded and seq_err pulses.
    - The expected index resets to 7.
    - If seg_sel == 7, the digit is taken as the first digit of a new frame, in the same cycle.
  - A transfer at index 0 completes the frame:
    - The shadow registers are copied to the frm_* outputs on the next edge.
    - frm_valid rises on that edge, so latency is 1 cycle from the last digit.
    - State moves to HOLD.
- State HOLD:
  - seg_ready = 0.
  - frm_* outputs stay stable while frm_valid = 1.
  - On frm_valid && frm_ready: frm_valid falls, the expected index resets to 7, state returns to COLLECT, and seg_ready = 1 from the next cycle.
- seg_ready is a registered function of state only; it never depends combinationally on seg_valid.
- frm_ready held high continuously gives 1 frame per 8 transfers + 2 cycles.
- seg_valid may deassert mid-frame; the partial frame is retained indefinitely.
- RST asserted mid-frame or during HOLD discards all partial or held data.

Decomposition:
- Package seg7_pkg holds:
  - the 7-segment code constants (shared with the display encoder);
  - the blank code 7'h7F;
  - the decode result type {nibble[3:0], blank, err}.
- One combinational sub-module seg7_decode maps 8-bit code to nibble/blank/dp/err. It is reused by any future display checker.

Test Plan:
- Reset:
  - Stimulus: assert RST mid-frame after 4 digits, release, then send a full frame.
  - Required: output outputs all 0; seq_err = 0; the first full frame decodes cleanly with no stale digits.
- Single frame:
  - Stimulus: send HEX7..HEX2 = FF, HEX1 = F9, HEX0 = A4 in order, with frm_ready = 1.
  - Required: frm_value = 32'h0000_0012, frm_blank = 8'hFC, frm_dp = 0, frm_err = 0; frm_valid high exactly 1 cycle after the HEX0 transfer.
- All glyphs:
  - Stimulus: frames covering codes 0–F plus DP-on (e.g. HEX0 = 8'h40 → digit 0 with DP).
  - Required: correct nibbles; frm_dp[0] = 1 for that digit.
- Invalid pattern:
  - Stimulus: HEX3 = 8'hFE.
  - Required: frm_err = 8'h08, nibble 3 = 0, other digits unaffected.
- Order error:
  - Stimulus: sequence 7,6,4 (CHECK_ORDER = 1).
  - Required: seq_err pulse on the index-4 transfer; the next frame 7..0 completes normally.
  - Stimulus: sel = 7 arriving mid-frame.
  - Required: seq_err pulses and a new frame starts with that digit.
- Back-pressure:
  - Stimulus: frm_ready = 0 for 20 cycles after a frame completes, with seg_valid held high.
  - Required: seg_ready = 0 and frm_* stable throughout; after frm_ready pulses, seg_ready = 1 on the next cycle and no digits are lost.
